// File: rtl/q10_shifter.sv
// q10_shifter: registered logical-left shifter with one-hot select.
// Ports: clk, rst (sync, high), d data, n one-hot shift select, w result.
module q10_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] w
);

  logic [WIDTH-1:0] term [WIDTH];
  logic [WIDTH-1:0] w_next;

  // Each select bit gates its own shifted copy; a non-one-hot
  // select ORs several copies together and n = 0 yields zero.
  for (genvar k = 0; k < WIDTH; k++) begin : g_term
    assign term[k] = {WIDTH{n[k]}} & (d << k);
  end

  always_comb begin
    w_next = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_next = w_next | term[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w <= '0;
    end else begin
      w <= w_next;
    end
  end

endmodule

// File: tb/tb_q10_shifter.sv
// tb_q10_shifter: directed table plus reset/latency sequences.
// Ports: none; drives q10_shifter with WIDTH = 8.
module tb_q10_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [7:0] n;
  logic [7:0] w;

  int cmp_cnt;
  int err_cnt;

  typedef struct {
    logic [7:0] d;
    logic [7:0] n;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [16];

  q10_shifter #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .d  (d),
    .n  (n),
    .w  (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string      name,
    input logic [7:0] exp
  );
    cmp_cnt++;
    if (w !== exp) begin
      err_cnt++;
      $display("FAIL %s: w=%h expected %h", name, w, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;

    vecs[0]  = '{8'hFF, 8'h80, 8'h80, "ones_k7"};
    vecs[1]  = '{8'hFF, 8'h10, 8'hF0, "ones_k4"};
    vecs[2]  = '{8'h00, 8'h20, 8'h00, "zero_d"};
    vecs[3]  = '{8'h58, 8'h01, 8'h58, "sw_k0"};
    vecs[4]  = '{8'h58, 8'h02, 8'hB0, "sw_k1"};
    vecs[5]  = '{8'h58, 8'h04, 8'h60, "sw_k2"};
    vecs[6]  = '{8'h58, 8'h08, 8'hC0, "sw_k3"};
    vecs[7]  = '{8'h58, 8'h10, 8'h80, "sw_k4"};
    vecs[8]  = '{8'h58, 8'h20, 8'h00, "sw_k5"};
    vecs[9]  = '{8'h58, 8'h40, 8'h00, "sw_k6"};
    vecs[10] = '{8'h58, 8'h80, 8'h00, "sw_k7"};
    vecs[11] = '{8'h01, 8'h03, 8'h03, "multi_03"};
    vecs[12] = '{8'hFF, 8'h00, 8'h00, "n_zero"};
    vecs[13] = '{8'h0F, 8'h11, 8'hFF, "multi_11"};
    vecs[14] = '{8'h81, 8'h81, 8'h81, "multi_81"};
    vecs[15] = '{8'hA5, 8'h40, 8'h40, "k6_lsb"};

    // reset with nonzero inputs must still clear w
    rst = 1'b1;
    d   = 8'hAA;
    n   = 8'h01;
    step();
    check("reset", 8'h00);
    step();
    check("reset_hold", 8'h00);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = vecs[i].d;
      n = vecs[i].n;
      step();
      check(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // mid-stream reset then release
    d = 8'hFF;
    n = 8'h10;
    step();
    check("pre_rst", 8'hF0);
    @(negedge clk);
    rst = 1'b1;
    d   = 8'hFF;
    n   = 8'h01;
    step();
    check("mid_rst", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_release", 8'hFF);

    // latency: input change must not reach w before the edge
    @(negedge clk);
    d = 8'h58;
    n = 8'h01;
    step();
    check("lat_base", 8'h58);
    n = 8'h02;
    #1;
    check("lat_hold", 8'h58);
    @(negedge clk);
    check("lat_hold_neg", 8'h58);
    step();
    check("lat_update", 8'hB0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/q10_shifter.md
Q10_SHIFTER -- requirements
Module: q10_shifter

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning the data width and the number of one-hot shift-select bits.
REQ-002 The block SHALL expose port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL expose port rst, input, 1 bit, reset; synchronous and active-high.
REQ-004 The block SHALL expose port d, input, WIDTH bits, the data word to be shifted.
REQ-005 The block SHALL expose port n, input, WIDTH bits, the one-hot shift select; bit k set selects a shift of k positions.
REQ-006 The block SHALL expose port w, output, WIDTH bits, the registered shift result.

Function
REQ-007 Shift direction SHALL be logical left (toward MSB), zero-filled at the LSB end; bits shifted past the MSB SHALL be discarded (no rotate).
REQ-008 For one-hot n with bit k set (k = 0..WIDTH-1), the next value of w SHALL be (d << k) truncated to WIDTH bits.
REQ-009 n = 8'b00000001 (k = 0) SHALL pass d through unchanged; n = 8'b10000000 (k = 7) SHALL yield {d[0], 7'b0}.
REQ-010 For non-one-hot n, the next w SHALL be the bitwise OR, over every set bit k of n, of (d << k) (AND-OR select structure).
REQ-011 For n = 0, the next w SHALL be all zeros.
REQ-012 Latency SHALL be exactly one clock: d and n sampled at rising edge t produce w valid after edge t, held until the next edge.
REQ-013 The block SHALL sample d and n on every clock edge; it SHALL have no handshake, no enable and no stall.
REQ-014 w SHALL be driven directly from a register, with no combinational path from d or n to w.
REQ-015 Widths SHALL be generic in WIDTH; no arithmetic carries or sign extension are involved.

Reset
REQ-016 When rst = 1 at a rising edge, w SHALL become all zeros on that edge, regardless of d and n.
REQ-017 rst SHALL take priority over the shift update; the first edge with rst = 0 SHALL load the shift result of the d and n sampled at that edge.
REQ-018 Asserting rst mid-stream SHALL discard the pending result with no residual state, because the block holds no state other than w.

Verification
REQ-019 The bench SHALL check full-ones shifts: d = 0xFF, n = 0x80 -> w = 0x80; d = 0xFF, n = 0x10 -> w = 0xF0; each one cycle after the inputs are applied.
REQ-020 The bench SHALL check a zero input: d = 0x00, n = 0x20 -> w = 0x00.
REQ-021 The bench SHALL sweep d = 0x58 with n = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80 -> w = 0x58, 0xB0, 0x60, 0xC0, 0x80, 0x00, 0x00, 0x00.
REQ-022 The bench SHALL check non-one-hot selects: d = 0x01, n = 0x03 -> w = 0x03; d = 0xFF, n = 0x00 -> w = 0x00.
REQ-023 The bench SHALL check reset: with w = 0xF0, assert rst for one edge with d = 0xFF, n = 0x01 -> w = 0x00; deassert rst -> w = 0xFF on the next edge.
REQ-024 The bench SHALL check latency: change n from 0x01 to 0x02 with d = 0x58 -> w stays 0x58 until the next rising edge, then becomes 0xB0.
